// File: rtl/heap_level_node_if.sv
// Single-address update handshake between adjacent heap levels.
// A transfer happens on the rising edge where valid && ready; the master holds
// valid and addr stable until that edge, and ready never depends on valid.
interface heap_level_node_if #(
  parameter int AW = 2
);
  logic          valid;
  logic [AW-1:0] addr;
  logic          ready;

  modport master (output valid, output addr, input ready);
  modport slave  (input valid, input addr, output ready);
endinterface

// File: rtl/heap_level_node.sv
// One level of a pipelined binary heap: on an update of upper entry p it compares
// p with its two children in the lower memory, swaps if needed and forwards the update.
module heap_level_node #(
  parameter int LEVEL    = 2,
  parameter int DATA_W   = 16,
  parameter int MAX_HEAP = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  heap_level_node_if.slave  upd_in,
  heap_level_node_if.master upd_out,
  output logic [LEVEL-1:0]  u_addr,
  input  logic [DATA_W-1:0] u_rdata,
  output logic [DATA_W-1:0] u_wdata,
  output logic              u_wren,
  output logic [LEVEL:0]    l_addr_a,
  input  logic [DATA_W-1:0] l_rdata_a,
  output logic [DATA_W-1:0] l_wdata,
  output logic              l_wren,
  output logic [LEVEL:0]    l_addr_b,
  input  logic [DATA_W-1:0] l_rdata_b,
  output logic [CNT_W-1:0]  swap_count,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    READ    = 3'd2,
    COMPARE = 3'd3,
    WRITE   = 3'd4,
    HOLD    = 3'd5
  } state_t;

  localparam logic [DATA_W-1:0]  SENTINEL = {DATA_W{(MAX_HEAP == 0)}};
  localparam logic [LEVEL+1:0]   CLR_END  = {1'b1, {(LEVEL+1){1'b0}}};

  state_t               state, state_n;
  logic [LEVEL-1:0]     p_q, p_n;
  logic [LEVEL+1:0]     clr_cnt, clr_cnt_n;
  logic [CNT_W-1:0]     cnt_n;
  logic                 in_ready_q, out_valid_q;
  logic [LEVEL:0]       out_addr_q;

  logic                 ready_n, in_ready_n, u_wren_n, l_wren_n, out_valid_n;
  logic [LEVEL-1:0]     u_addr_n;
  logic [DATA_W-1:0]    u_wdata_n, l_wdata_n;
  logic [LEVEL:0]       l_addr_a_n, l_addr_b_n, out_addr_n;

  logic                 sel_right, do_swap;
  logic [DATA_W-1:0]    child;

  function automatic logic better(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    if (MAX_HEAP != 0) return x > y;
    else               return x < y;
  endfunction

  // Ties between siblings resolve to the left child; ties with the parent never swap.
  assign sel_right = better(l_rdata_b, l_rdata_a);
  assign child     = sel_right ? l_rdata_b : l_rdata_a;
  assign do_swap   = better(child, u_rdata);

  assign upd_in.ready  = in_ready_q;
  assign upd_out.valid = out_valid_q;
  assign upd_out.addr  = out_addr_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CLEAR;
      p_q         <= '0;
      clr_cnt     <= '0;
      swap_count  <= '0;
      ready       <= 1'b0;
      in_ready_q  <= 1'b0;
      u_addr      <= '0;
      u_wdata     <= '0;
      u_wren      <= 1'b0;
      l_addr_a    <= '0;
      l_addr_b    <= '0;
      l_wdata     <= '0;
      l_wren      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      state       <= state_n;
      p_q         <= p_n;
      clr_cnt     <= clr_cnt_n;
      swap_count  <= cnt_n;
      ready       <= ready_n;
      in_ready_q  <= in_ready_n;
      u_addr      <= u_addr_n;
      u_wdata     <= u_wdata_n;
      u_wren      <= u_wren_n;
      l_addr_a    <= l_addr_a_n;
      l_addr_b    <= l_addr_b_n;
      l_wdata     <= l_wdata_n;
      l_wren      <= l_wren_n;
      out_valid_q <= out_valid_n;
      out_addr_q  <= out_addr_n;
    end
  end

  // Outputs are computed for the state being entered, so every output is a flop.
  always_comb begin
    state_n     = state;
    p_n         = p_q;
    clr_cnt_n   = clr_cnt;
    cnt_n       = swap_count;
    ready_n     = 1'b0;
    in_ready_n  = 1'b0;
    u_addr_n    = '0;
    u_wdata_n   = '0;
    u_wren_n    = 1'b0;
    l_addr_a_n  = '0;
    l_addr_b_n  = '0;
    l_wdata_n   = '0;
    l_wren_n    = 1'b0;
    out_valid_n = 1'b0;
    out_addr_n  = '0;
    unique case (state)
      CLEAR: begin
        if (clr_cnt == CLR_END) begin
          state_n = IDLE;
        end else begin
          l_wren_n   = 1'b1;
          l_addr_a_n = clr_cnt[LEVEL:0];
          l_wdata_n  = SENTINEL;
          clr_cnt_n  = clr_cnt + (LEVEL+2)'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_n    = CLEAR;
          cnt_n      = '0;
          l_wren_n   = 1'b1;
          l_addr_a_n = '0;
          l_wdata_n  = SENTINEL;
          clr_cnt_n  = (LEVEL+2)'(1);
        end else if (upd_in.valid) begin
          state_n    = READ;
          p_n        = upd_in.addr;
          u_addr_n   = upd_in.addr;
          l_addr_a_n = {upd_in.addr, 1'b0};
          l_addr_b_n = {upd_in.addr, 1'b1};
        end
      end
      READ: begin
        state_n    = COMPARE;
        u_addr_n   = p_q;
        l_addr_a_n = {p_q, 1'b0};
        l_addr_b_n = {p_q, 1'b1};
      end
      COMPARE: begin
        if (do_swap) begin
          state_n     = WRITE;
          u_wren_n    = 1'b1;
          u_addr_n    = p_q;
          u_wdata_n   = child;
          l_wren_n    = 1'b1;
          l_addr_a_n  = {p_q, sel_right};
          l_wdata_n   = u_rdata;
          out_valid_n = 1'b1;
          out_addr_n  = {p_q, sel_right};
          if (swap_count != {CNT_W{1'b1}}) cnt_n = swap_count + CNT_W'(1);
        end else begin
          state_n = IDLE;
        end
      end
      WRITE, HOLD: begin
        if (upd_out.ready) begin
          state_n = IDLE;
        end else begin
          state_n     = HOLD;
          out_valid_n = 1'b1;
          out_addr_n  = out_addr_q;
        end
      end
      default: state_n = CLEAR;
    endcase
    if (state_n == IDLE) begin
      ready_n    = 1'b1;
      in_ready_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_heap_level_node.sv
// Bench for heap_level_node: a min-heap instance driven from a vector table plus random
// updates, and a max-heap instance with a 2-bit counter for order and saturation.
module tb_heap_level_node;
  localparam int LEVEL = 2;
  localparam int DW    = 16;
  localparam int AW    = LEVEL;
  localparam int LW    = LEVEL + 1;

  typedef struct {
    logic [AW-1:0] p;
    logic [DW-1:0] up;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          swap;
    logic [LW-1:0] c;
    logic [DW-1:0] eu;
    logic [DW-1:0] elc;
    int            hold;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int a_wr_pulses = 0;
  logic [LW-1:0] exp_q[$];

  // ---------------- min-heap instance ----------------
  logic a_clr, a_ready, a_u_wren, a_l_wren;
  logic [AW-1:0] a_u_addr;
  logic [LW-1:0] a_l_addr_a, a_l_addr_b;
  logic [DW-1:0] a_u_rdata, a_u_wdata, a_l_rdata_a, a_l_rdata_b, a_l_wdata;
  logic [15:0] a_swap_count;
  logic [2:0] a_state;
  heap_level_node_if #(.AW(AW)) a_in();
  heap_level_node_if #(.AW(LW)) a_out();

  heap_level_node #(.LEVEL(LEVEL), .DATA_W(DW), .MAX_HEAP(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .ready(a_ready),
    .upd_in(a_in), .upd_out(a_out),
    .u_addr(a_u_addr), .u_rdata(a_u_rdata), .u_wdata(a_u_wdata), .u_wren(a_u_wren),
    .l_addr_a(a_l_addr_a), .l_rdata_a(a_l_rdata_a), .l_wdata(a_l_wdata), .l_wren(a_l_wren),
    .l_addr_b(a_l_addr_b), .l_rdata_b(a_l_rdata_b),
    .swap_count(a_swap_count), .state_dbg(a_state)
  );

  logic [DW-1:0] a_upper [4];
  logic [DW-1:0] a_lower [8];
  logic a_pk = 1'b0;
  logic [AW-1:0] a_pk_p;
  logic [DW-1:0] a_pk_up, a_pk_l, a_pk_r;

  always @(posedge clk) begin
    a_u_rdata   <= a_upper[a_u_addr];
    a_l_rdata_a <= a_lower[a_l_addr_a];
    a_l_rdata_b <= a_lower[a_l_addr_b];
    if (a_u_wren) a_upper[a_u_addr] <= a_u_wdata;
    if (a_l_wren) a_lower[a_l_addr_a] <= a_l_wdata;
    if (a_pk) begin
      a_upper[a_pk_p]         <= a_pk_up;
      a_lower[{a_pk_p, 1'b0}] <= a_pk_l;
      a_lower[{a_pk_p, 1'b1}] <= a_pk_r;
    end
  end

  // ---------------- max-heap instance, 2-bit counter ----------------
  logic b_clr, b_ready, b_u_wren, b_l_wren;
  logic [AW-1:0] b_u_addr;
  logic [LW-1:0] b_l_addr_a, b_l_addr_b;
  logic [DW-1:0] b_u_rdata, b_u_wdata, b_l_rdata_a, b_l_rdata_b, b_l_wdata;
  logic [1:0] b_swap_count;
  logic [2:0] b_state;
  heap_level_node_if #(.AW(AW)) b_in();
  heap_level_node_if #(.AW(LW)) b_out();

  heap_level_node #(.LEVEL(LEVEL), .DATA_W(DW), .MAX_HEAP(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .ready(b_ready),
    .upd_in(b_in), .upd_out(b_out),
    .u_addr(b_u_addr), .u_rdata(b_u_rdata), .u_wdata(b_u_wdata), .u_wren(b_u_wren),
    .l_addr_a(b_l_addr_a), .l_rdata_a(b_l_rdata_a), .l_wdata(b_l_wdata), .l_wren(b_l_wren),
    .l_addr_b(b_l_addr_b), .l_rdata_b(b_l_rdata_b),
    .swap_count(b_swap_count), .state_dbg(b_state)
  );

  logic [DW-1:0] b_upper [4];
  logic [DW-1:0] b_lower [8];
  logic b_pk = 1'b0;
  logic [AW-1:0] b_pk_p;
  logic [DW-1:0] b_pk_up, b_pk_l, b_pk_r;

  always @(posedge clk) begin
    b_u_rdata   <= b_upper[b_u_addr];
    b_l_rdata_a <= b_lower[b_l_addr_a];
    b_l_rdata_b <= b_lower[b_l_addr_b];
    if (b_u_wren) b_upper[b_u_addr] <= b_u_wdata;
    if (b_l_wren) b_lower[b_l_addr_a] <= b_l_wdata;
    if (b_pk) begin
      b_upper[b_pk_p]         <= b_pk_up;
      b_lower[{b_pk_p, 1'b0}] <= b_pk_l;
      b_lower[{b_pk_p, 1'b1}] <= b_pk_r;
    end
  end

  // ---------------- scoreboard: upd_out transfers of the min-heap instance ----------------
  always begin
    @(negedge clk);
    #1;
    if (a_u_wren) a_wr_pulses++;
    if (a_out.valid && a_out.ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL upd_out_unexpected: got transfer addr %0d, expected none", a_out.addr);
      end else begin
        logic [LW-1:0] e;
        e = exp_q.pop_front();
        if (a_out.addr !== e) begin
          errors++;
          $display("FAIL upd_out_addr: got %0d, expected %0d", a_out.addr, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (a_in.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("a_idle_wait", {31'd0, a_in.ready}, 32'd1);
  endtask

  task automatic poke_a(input logic [AW-1:0] p, input logic [DW-1:0] up, l, r);
    a_pk_p = p; a_pk_up = up; a_pk_l = l; a_pk_r = r; a_pk = 1'b1;
    @(negedge clk);
    a_pk = 1'b0;
  endtask

  // Eight sentinel writes at addresses 0..7, then ready.
  task automatic a_check_clear(input string tag);
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_clr = 1'b0;
      a_in.valid = 1'b0;
      if (i == 0) begin
        check({tag, "_state"}, a_state, 32'd0);
        check({tag, "_swap_count"}, a_swap_count, 32'd0);
      end
      check({tag, "_l_wren"}, a_l_wren, 32'd1);
      check({tag, "_l_addr_a"}, a_l_addr_a, i);
      check({tag, "_l_wdata"}, a_l_wdata, 32'hFFFF);
      check({tag, "_busy_in_ready"}, {a_in.ready, a_ready, a_out.valid}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_ready"}, {a_ready, a_in.ready, a_l_wren}, 32'b110);
    for (int i = 0; i < 8; i++) if (a_lower[i] !== 16'hFFFF) bad++;
    check({tag, "_lower_sentinel"}, bad, 32'd0);
  endtask

  task automatic a_run(input vec_t v);
    int wr0;
    wait_idle_a();
    poke_a(v.p, v.up, v.l, v.r);
    a_out.ready = (v.hold == 0);
    if (v.swap) begin
      exp_q.push_back(v.c);
      exp_cnt++;
    end
    wr0 = a_wr_pulses;
    a_in.valid = 1'b1;
    a_in.addr = v.p;
    @(negedge clk);
    a_in.valid = 1'b0;
    check("read_u_addr", a_u_addr, v.p);
    check("read_l_addr_a", a_l_addr_a, {v.p, 1'b0});
    check("read_l_addr_b", a_l_addr_b, {v.p, 1'b1});
    check("read_in_ready", {a_in.ready, a_ready}, 32'd0);
    @(negedge clk);
    check("cmp_state_wren", {a_state, a_u_wren, a_l_wren}, {3'd3, 2'b00});
    @(negedge clk);
    if (v.swap) begin
      check("wr_u_wren_addr", {a_u_wren, a_u_addr}, {1'b1, v.p});
      check("wr_u_wdata", a_u_wdata, v.eu);
      check("wr_l_wren_addr", {a_l_wren, a_l_addr_a}, {1'b1, v.c});
      check("wr_l_wdata", a_l_wdata, v.elc);
      check("wr_upd_out", {a_out.valid, a_out.addr}, {1'b1, v.c});
      check("wr_swap_count", a_swap_count, exp_cnt);
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clk);
        check("hold_state", a_state, 32'd5);
        check("hold_upd_out", {a_out.valid, a_out.addr}, {1'b1, v.c});
        check("hold_quiet", {a_u_wren, a_l_wren, a_in.ready}, 32'd0);
      end
      a_out.ready = 1'b1;
      @(negedge clk);
    end else begin
      check("noswap_quiet", {a_out.valid, a_u_wren, a_l_wren}, 32'd0);
    end
    check("idle_in_ready", {a_in.ready, a_ready}, 32'b11);
    check("mem_upper", a_upper[v.p], v.eu);
    check("mem_lower", a_lower[v.c], v.elc);
    check("write_pulses", a_wr_pulses - wr0, {31'd0, v.swap});
  endtask

  function automatic vec_t model(input logic [AW-1:0] p, input logic [DW-1:0] up, l, r);
    vec_t v;
    logic [DW-1:0] ch;
    logic [LW-1:0] c;
    v.p = p; v.up = up; v.l = l; v.r = r; v.hold = 0;
    if (r < l) begin ch = r; c = {p, 1'b1}; end
    else       begin ch = l; c = {p, 1'b0}; end
    if (ch < up) begin
      v.swap = 1'b1; v.c = c; v.eu = ch; v.elc = up;
    end else begin
      v.swap = 1'b0; v.c = {p, 1'b0}; v.eu = up; v.elc = l;
    end
    return v;
  endfunction

  task automatic b_run(input logic [AW-1:0] p, input logic [DW-1:0] up, l, r,
                       input logic [LW-1:0] ec, input logic [DW-1:0] eu, elc,
                       input logic [1:0] ecnt);
    int n = 0;
    while (b_in.ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    b_pk_p = p; b_pk_up = up; b_pk_l = l; b_pk_r = r; b_pk = 1'b1;
    @(negedge clk);
    b_pk = 1'b0;
    b_in.valid = 1'b1;
    b_in.addr = p;
    @(negedge clk);
    b_in.valid = 1'b0;
    n = 0;
    while (b_out.valid !== 1'b1 && n < 6) begin @(negedge clk); n++; end
    check("b_upd_out", {b_out.valid, b_out.addr}, {1'b1, ec});
    check("b_swap_count", b_swap_count, ecnt);
    @(negedge clk);
    check("b_mem_upper", b_upper[p], eu);
    check("b_mem_lower", b_lower[ec], elc);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[9];
    int nz;
    a_clr = 1'b0; b_clr = 1'b0;
    a_in.valid = 1'b0; a_in.addr = '0; a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_in.addr = '0; b_out.ready = 1'b1;

    tbl[0] = '{2'd1, 16'd9,     16'd5,     16'd7,     1'b1, 3'd2, 16'd5,     16'd9,     0};
    tbl[1] = '{2'd1, 16'd9,     16'd4,     16'd4,     1'b1, 3'd2, 16'd4,     16'd9,     0};
    tbl[2] = '{2'd1, 16'd3,     16'd3,     16'd8,     1'b0, 3'd2, 16'd3,     16'd3,     0};
    tbl[3] = '{2'd0, 16'd10,    16'd12,    16'd2,     1'b1, 3'd1, 16'd2,     16'd10,    0};
    tbl[4] = '{2'd3, 16'h8000,  16'hFFFF,  16'h7FFF,  1'b1, 3'd7, 16'h7FFF,  16'h8000,  0};
    tbl[5] = '{2'd2, 16'd0,     16'd0,     16'd0,     1'b0, 3'd4, 16'd0,     16'd0,     0};
    tbl[6] = '{2'd2, 16'hFFFF,  16'hFFFE,  16'hFFFF,  1'b1, 3'd4, 16'hFFFE,  16'hFFFF,  0};
    tbl[7] = '{2'd3, 16'd5,     16'd6,     16'd5,     1'b0, 3'd6, 16'd5,     16'd6,     0};
    tbl[8] = '{2'd0, 16'd20,    16'd30,    16'd1,     1'b1, 3'd1, 16'd1,     16'd20,    5};

    repeat (2) @(negedge clk);
    check("rst_a_outputs", {a_ready, a_in.ready, a_l_wren, a_u_wren, a_out.valid}, 32'd0);
    check("rst_a_swap_count", a_swap_count, 32'd0);
    check("rst_b_outputs", {b_ready, b_in.ready, b_l_wren, b_swap_count}, 32'd0);
    rst = 1'b1;
    a_check_clear("clr_rst");
    nz = 0;
    for (int i = 0; i < 8; i++) if (b_lower[i] !== 16'h0000) nz++;
    check("b_clear_zero", nz, 32'd0);
    check("b_ready", {b_ready, b_in.ready}, 32'b11);

    for (int i = 0; i < 9; i++) a_run(tbl[i]);
    for (int i = 0; i < 6; i++)
      a_run(model(2'($urandom_range(0, 3)), 16'($urandom_range(0, 15)),
                  16'($urandom_range(0, 15)), 16'($urandom_range(0, 15))));

    // clr wins over a simultaneous update request
    wait_idle_a();
    check("cnt_before_clr", a_swap_count, exp_cnt);
    a_clr = 1'b1;
    a_in.valid = 1'b1;
    a_in.addr = 2'd1;
    a_check_clear("clr_req");
    exp_cnt = 0;
    a_run(tbl[3]);

    b_run(2'd0, 16'd2, 16'd6, 16'd9, 3'd1, 16'd9, 16'd2, 2'd1);
    b_run(2'd1, 16'd2, 16'd6, 16'd9, 3'd3, 16'd9, 16'd2, 2'd2);
    b_run(2'd2, 16'd2, 16'd6, 16'd9, 3'd5, 16'd9, 16'd2, 2'd3);
    b_run(2'd3, 16'd2, 16'd6, 16'd9, 3'd7, 16'd9, 16'd2, 2'd3);

    // asynchronous reset while holding an undelivered update
    wait_idle_a();
    poke_a(2'd1, 16'd9, 16'd5, 16'd7);
    a_out.ready = 1'b0;
    a_in.valid = 1'b1;
    a_in.addr = 2'd1;
    @(negedge clk);
    a_in.valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_hold", {a_state, a_out.valid}, {3'd5, 1'b1});
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outputs", {a_out.valid, a_in.ready, a_ready, a_u_wren, a_l_wren}, 32'd0);
    check("async_rst_regs", {a_swap_count, a_state, a_out.addr, a_l_addr_a}, 32'd0);
    a_out.ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    a_check_clear("clr_after_hold_rst");
    a_run(tbl[0]);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
